// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM encodings and the bit-counter width.
package word_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter spans 0..w-1; the guard keeps the width at least one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/word_serializer_shift_register_piso.sv
// Parallel-in/serial-out shift register: load wins over shift, LSB leaves first, zeros enter at the MSB.
module shift_register_piso #(
  parameter int WORD_LENGTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [WORD_LENGTH-1:0] parallel_in,
  output logic                   serial
);

  logic [WORD_LENGTH-1:0] shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= parallel_in;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WORD_LENGTH-1:1]};
    end
  end

  assign serial = shreg[0];

endmodule

// File: rtl/word_serializer.sv
// Word serializer top: IDLE/SHIFT/DONE FSM and bit counter around a PISO shift register.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WORD_LENGTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] data_in,
  output logic                   ready,
  output logic                   serial_out,
  output logic                   serial_valid,
  input  logic                   sink_ready,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  localparam int CW = cnt_width(WORD_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] count;
  logic          load;
  logic          accept;
  logic          last_accept;

  // Handshake: a bit transfers on any rising edge where serial_valid and
  // sink_ready are both 1; serial_out is held unchanged until that edge.
  assign load        = (state == ST_IDLE) && start;
  assign accept      = (state == ST_SHIFT) && sink_ready;
  assign last_accept = accept && (count == LAST);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_accept) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The final accept leaves the counter at WORD_LENGTH-1 rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (accept && !last_accept) begin
      count <= count + CW'(1);
    end
  end

  shift_register_piso #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_piso (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .shift      (accept),
    .parallel_in(data_in),
    .serial     (serial_out)
  );

  assign ready        = (state == ST_IDLE);
  assign serial_valid = (state == ST_SHIFT);
  assign done         = (state == ST_DONE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer with WORD_LENGTH = 6.
module tb_word_serializer;
  import word_serializer_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready;
  logic         serial_out;
  logic         serial_valid;
  logic         sink_ready = 1'b1;
  logic         done;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc_a;
  int start_cyc_b;

  word_serializer #(.WORD_LENGTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .ready       (ready),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .sink_ready  (sink_ready),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word; bit stall_at is back-pressured for stall_n cycles.
  // With poke set, start is raised with data_in = 0 during the stall and in DONE.
  task automatic run_word(input logic [W-1:0] word, input int stall_at, input int stall_n,
                          input bit poke, output int start_cyc);
    int t0;
    check("pre_ready", 32'(ready), 32'd1);
    start      = 1'b1;
    data_in    = word;
    sink_ready = 1'b1;
    tick();
    t0        = cyc;
    start_cyc = cyc;
    start     = 1'b0;
    data_in   = W'($urandom_range(0, (1 << W) - 1));
    for (int k = 0; k < W; k++) begin
      check($sformatf("valid_b%0d", k), 32'(serial_valid), 32'd1);
      check($sformatf("bit_b%0d", k), 32'(serial_out), 32'(word[k]));
      if (k == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          sink_ready = 1'b0;
          if (poke) begin
            start   = 1'b1;
            data_in = '0;
          end
          tick();
          check($sformatf("stall_bit_b%0d", k), 32'(serial_out), 32'(word[k]));
          check("stall_valid", 32'(serial_valid), 32'd1);
          check("stall_no_done", 32'(done), 32'd0);
        end
        start      = 1'b0;
        sink_ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(serial_valid), 32'd0);
    check("done_ready", 32'(ready), 32'd0);
    check("done_state", 32'(state_dbg), 32'(ST_DONE));
    if (poke) begin
      start   = 1'b1;
      data_in = '0;
    end
    tick();
    start = 1'b0;
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    check("latency", 32'(cyc - t0), 32'(W + 2 + stall_n - 1));
  endtask

  initial begin
    int dummy;
    // Reset check with random inputs
    for (int i = 0; i < 3; i++) begin
      start      = 1'($urandom_range(0, 1));
      sink_ready = 1'($urandom_range(0, 1));
      data_in    = W'($urandom_range(0, (1 << W) - 1));
      tick();
    end
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(serial_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sout", 32'(serial_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    start      = 1'b0;
    sink_ready = 1'b1;
    reset      = 1'b1;
    tick();
    check("post_rst_ready", 32'(ready), 32'd1);

    // Basic send: 6'b101101 -> 1,0,1,1,0,1
    run_word(6'b101101, -1, 0, 1'b0, dummy);

    // Back-pressure on bit 2 for 3 cycles
    run_word(6'b101101, 2, 3, 1'b0, dummy);

    // Start while busy (SHIFT stall and DONE); no second transfer follows
    run_word(6'b101101, 1, 2, 1'b1, dummy);
    tick();
    check("busy_no_restart_valid", 32'(serial_valid), 32'd0);
    check("busy_no_restart_ready", 32'(ready), 32'd1);

    // Reset after the 3rd accepted bit of 6'b110110
    start   = 1'b1;
    data_in = 6'b110110;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("mid_bit3", 32'(serial_out), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_valid", 32'(serial_valid), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sout", 32'(serial_out), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_after_done", 32'(done), 32'd0);
    check("mid_after_ready", 32'(ready), 32'd1);
    run_word(6'b010010, -1, 0, 1'b0, dummy);

    // Back-to-back words
    run_word(6'b111111, -1, 0, 1'b0, start_cyc_a);
    run_word(6'b000001, -1, 0, 1'b0, start_cyc_b);
    check("b2b_gap", 32'(start_cyc_b - start_cyc_a), 32'(W + 2));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
